// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module : mips_pkg
// Desc   : Shared encodings for the MIPS R2000 execute stage (ALU ops, funct
//          codes, control-field bit positions).
// Rev    : 1.0
// ============================================================================
package mips_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_ADDU  = 4'd1,
    ALU_SUB   = 4'd2,
    ALU_SUBU  = 4'd3,
    ALU_AND   = 4'd4,
    ALU_OR    = 4'd5,
    ALU_XOR   = 4'd6,
    ALU_NOR   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_SLL   = 4'd10,
    ALU_SRL   = 4'd11,
    ALU_SRA   = 4'd12,
    ALU_LUI   = 4'd13,
    ALU_LINK  = 4'd14,
    ALU_FUNCT = 4'd15
  } alu_op_e;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam int EX_REG_DST    = 5;
  localparam int EX_ALU_OP_MSB = 4;
  localparam int EX_ALU_OP_LSB = 1;
  localparam int EX_ALU_SRC    = 0;

  localparam int M_BRANCH    = 2;
  localparam int M_MEM_READ  = 1;
  localparam int M_MEM_WRITE = 0;

  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;

  localparam logic [4:0] LINK_REG = 5'd31;

endpackage
`default_nettype wire

// File: rtl/ex_alu.sv
`default_nettype none
// ============================================================================
// Module : ex_alu
// Desc   : Combinational MIPS ALU with funct decode; EX_OVERFLOW_TRAP_EN
//          enables signed-overflow detection for ADD/SUB.
// Rev    : 1.0
// ============================================================================
module ex_alu
  import mips_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  alu_op_e       op,
  input  logic [4:0]    shamt,
  input  logic [5:0]    funct,
  input  logic [15:0]   lui_imm,
  input  logic [DW-1:0] pc,
  output logic [DW-1:0] result,
  output logic          zero,
  output logic          over
);

  alu_op_e       op_eff;
  logic [DW-1:0] sum;
  logic [DW-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  // R-type instructions are folded onto the direct op codes; JR and unknown
  // functs stay as ALU_FUNCT, which yields a zero result below.
  always_comb begin
    op_eff = op;
    if (op == ALU_FUNCT) begin
      case (funct)
        FN_ADD:  op_eff = ALU_ADD;
        FN_ADDU: op_eff = ALU_ADDU;
        FN_SUB:  op_eff = ALU_SUB;
        FN_SUBU: op_eff = ALU_SUBU;
        FN_AND:  op_eff = ALU_AND;
        FN_OR:   op_eff = ALU_OR;
        FN_XOR:  op_eff = ALU_XOR;
        FN_NOR:  op_eff = ALU_NOR;
        FN_SLT:  op_eff = ALU_SLT;
        FN_SLTU: op_eff = ALU_SLTU;
        FN_SLL:  op_eff = ALU_SLL;
        FN_SRL:  op_eff = ALU_SRL;
        FN_SRA:  op_eff = ALU_SRA;
        default: op_eff = ALU_FUNCT;
      endcase
    end
  end

  always_comb begin
    result = '0;
    case (op_eff)
      ALU_ADD, ALU_ADDU: result = sum;
      ALU_SUB, ALU_SUBU: result = diff;
      ALU_AND:           result = a & b;
      ALU_OR:            result = a | b;
      ALU_XOR:           result = a ^ b;
      ALU_NOR:           result = ~(a | b);
      ALU_SLT:           result = DW'($signed(a) < $signed(b));
      ALU_SLTU:          result = DW'(a < b);
      ALU_SLL:           result = b << shamt;
      ALU_SRL:           result = b >> shamt;
      ALU_SRA:           result = $unsigned($signed(b) >>> shamt);
      ALU_LUI:           result = DW'({lui_imm, 16'h0000});
      ALU_LINK:          result = pc + DW'(8);
      default:           result = '0;
    endcase
  end

  assign zero = (result == '0);

`ifdef EX_OVERFLOW_TRAP_EN
  always_comb begin
    case (op_eff)
      ALU_ADD: over = (a[DW-1] == b[DW-1]) && (sum[DW-1]  != a[DW-1]);
      ALU_SUB: over = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
      default: over = 1'b0;
    endcase
  end
`else
  assign over = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module : ex_stage
// Desc   : MIPS R2000 execute stage: operand forwarding, ALU, destination
//          select and EX/MEM register. EX_OVERFLOW_TRAP_EN enables overflow
//          suppression of M/WB controls.
// Rev    : 1.0
// ============================================================================
module ex_stage
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] pc_ex,
  input  logic [DW-1:0] data_1,
  input  logic [DW-1:0] data_2,
  input  logic [RW-1:0] rs,
  input  logic [RW-1:0] rt,
  input  logic [RW-1:0] rd,
  input  logic [5:0]    ex,
  input  logic [2:0]    m,
  input  logic [1:0]    wb,
  input  logic          wb_reg_write,
  input  logic [RW-1:0] write_register_mem,
  input  logic          flush_ex,
  input  logic [DW-1:0] write_data_reg,
  input  logic [DW-1:0] imm,
  output logic          zero,
  output logic          over,
  output logic [DW-1:0] res,
  output logic [RW-1:0] write_register_ex,
  output logic [DW-1:0] write_data_ex,
  output logic [2:0]    m_MEM,
  output logic [1:0]    wb_MEM
);

  logic [DW-1:0] res_q, res_d;
  logic [RW-1:0] wreg_q, wreg_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [2:0]    m_q, m_d;
  logic [1:0]    wb_q, wb_d;

  logic [DW-1:0] fwd_a, fwd_b, alu_b, alu_res;
  logic          exmem_fwd, memwb_fwd, kill;
  alu_op_e       alu_op;

  assign alu_op = alu_op_e'(ex[EX_ALU_OP_MSB:EX_ALU_OP_LSB]);

  // A load sitting in MEM has no data yet; ID stalls that case instead.
  assign exmem_fwd = wb_q[WB_REG_WRITE] && !wb_q[WB_MEM_TO_REG] && (wreg_q != '0);
  assign memwb_fwd = wb_reg_write && (write_register_mem != '0);

  always_comb begin
    fwd_a = data_1;
    if (exmem_fwd && (wreg_q == rs))
      fwd_a = res_q;
    else if (memwb_fwd && (write_register_mem == rs))
      fwd_a = write_data_reg;

    fwd_b = data_2;
    if (exmem_fwd && (wreg_q == rt))
      fwd_b = res_q;
    else if (memwb_fwd && (write_register_mem == rt))
      fwd_b = write_data_reg;
  end

  assign alu_b = ex[EX_ALU_SRC] ? imm : fwd_b;

  ex_alu #(
    .DW (DW)
  ) u_alu (
    .a       (fwd_a),
    .b       (alu_b),
    .op      (alu_op),
    .shamt   (imm[10:6]),
    .funct   (imm[5:0]),
    .lui_imm (imm[15:0]),
    .pc      (pc_ex),
    .result  (alu_res),
    .zero    (zero),
    .over    (over)
  );

`ifdef EX_OVERFLOW_TRAP_EN
  assign kill = flush_ex | over;
`else
  assign kill = flush_ex;
`endif

  always_comb begin
    res_d   = alu_res;
    wdata_d = fwd_b;
    wreg_d  = ex[EX_REG_DST] ? rd : rt;
    if (alu_op == ALU_LINK)
      wreg_d = RW'(LINK_REG);
    m_d  = m;
    wb_d = wb;
    if (kill) begin
      m_d  = '0;
      wb_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      wreg_q  <= '0;
      wdata_q <= '0;
      m_q     <= '0;
      wb_q    <= '0;
    end else begin
      res_q   <= res_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      m_q     <= m_d;
      wb_q    <= wb_d;
    end
  end

  assign res               = res_q;
  assign write_register_ex = wreg_q;
  assign write_data_ex     = wdata_q;
  assign m_MEM             = m_q;
  assign wb_MEM            = wb_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_ex_stage
// Desc   : Scoreboard testbench for ex_stage (default and EX_OVERFLOW_TRAP_EN).
// Rev    : 1.0
// ============================================================================
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_ex, data_1, data_2, write_data_reg, imm;
  logic [4:0]  rs, rt, rd, write_register_mem;
  logic [5:0]  ex;
  logic [2:0]  m;
  logic [1:0]  wb;
  logic        wb_reg_write, flush_ex;
  logic        zero, over;
  logic [31:0] res, write_data_ex;
  logic [4:0]  write_register_ex;
  logic [2:0]  m_MEM;
  logic [1:0]  wb_MEM;

`ifdef EX_OVERFLOW_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // {res, write_register_ex, write_data_ex, m_MEM, wb_MEM}
  typedef logic [73:0] out_t;
  out_t sb[$];
  out_t got, want;
  int   n_cmp = 0;
  int   n_err = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] im;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } alu_vec_t;

  localparam alu_vec_t VEC [30] = '{
    '{4'd1,  32'h0,     32'd3,        32'd4,        32'd7},
    '{4'd3,  32'h0,     32'd3,        32'd4,        32'hFFFFFFFF},
    '{4'd4,  32'h0,     32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F},
    '{4'd5,  32'h0,     32'hF0F000FF, 32'h0FF00F0F, 32'hFFF00FFF},
    '{4'd6,  32'h0,     32'hF0F000FF, 32'h0FF00F0F, 32'hFF000FF0},
    '{4'd7,  32'h0,     32'hF0F000FF, 32'h0FF00F0F, 32'h000FF000},
    '{4'd8,  32'h0,     32'hFFFFFFFF, 32'd1,        32'd1},
    '{4'd9,  32'h0,     32'hFFFFFFFF, 32'd1,        32'd0},
    '{4'd10, 32'h100,   32'h0,        32'h80000010, 32'h00000100},
    '{4'd11, 32'h100,   32'h0,        32'h80000010, 32'h08000001},
    '{4'd12, 32'h100,   32'h0,        32'h80000010, 32'hF8000001},
    '{4'd13, 32'hABCD,  32'h0,        32'h0,        32'hABCD0000},
    '{4'd15, 32'h20,    32'd2,        32'd3,        32'd5},
    '{4'd15, 32'h23,    32'd2,        32'd3,        32'hFFFFFFFF},
    '{4'd15, 32'h24,    32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F},
    '{4'd15, 32'h27,    32'hF0F000FF, 32'h0FF00F0F, 32'h000FF000},
    '{4'd15, 32'h2A,    32'hFFFFFFFF, 32'd1,        32'd1},
    '{4'd15, 32'h2B,    32'hFFFFFFFF, 32'd1,        32'd0},
    '{4'd15, 32'h100,   32'h0,        32'h80000010, 32'h00000100},
    '{4'd15, 32'h102,   32'h0,        32'h80000010, 32'h08000001},
    '{4'd15, 32'h103,   32'h0,        32'h80000010, 32'hF8000001},
    '{4'd15, 32'h08,    32'd5,        32'd6,        32'd0},
    '{4'd15, 32'h3F,    32'd5,        32'd6,        32'd0},
    '{4'd2,  32'h0,     32'd9,        32'd4,        32'd5},
    '{4'd0,  32'h0,     32'd2,        32'd3,        32'd5},
    '{4'd15, 32'h21,    32'hFFFFFFFF, 32'd1,        32'd0},
    '{4'd15, 32'h25,    32'hF0F000FF, 32'h0FF00F0F, 32'hFFF00FFF},
    '{4'd15, 32'h26,    32'hF0F000FF, 32'h0FF00F0F, 32'hFF000FF0},
    '{4'd15, 32'h22,    32'd9,        32'd4,        32'd5},
    '{4'd9,  32'h0,     32'd1,        32'hFFFFFFFF, 32'd1}
  };

  ex_stage #(
    .DW (32),
    .RW (5)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .pc_ex              (pc_ex),
    .data_1             (data_1),
    .data_2             (data_2),
    .rs                 (rs),
    .rt                 (rt),
    .rd                 (rd),
    .ex                 (ex),
    .m                  (m),
    .wb                 (wb),
    .wb_reg_write       (wb_reg_write),
    .write_register_mem (write_register_mem),
    .flush_ex           (flush_ex),
    .write_data_reg     (write_data_reg),
    .imm                (imm),
    .zero               (zero),
    .over               (over),
    .res                (res),
    .write_register_ex  (write_register_ex),
    .write_data_ex      (write_data_ex),
    .m_MEM              (m_MEM),
    .wb_MEM             (wb_MEM)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                           input logic [31:0] a, input logic [31:0] b, input logic [5:0] e,
                           input logic [2:0] mm, input logic [1:0] w, input logic [31:0] im);
    rs = s; rt = t; rd = d; data_1 = a; data_2 = b; ex = e; m = mm; wb = w; imm = im;
  endtask

  task automatic idle;
    flush_ex = 1'b0; wb_reg_write = 1'b0; write_register_mem = 5'd0;
    write_data_reg = 32'h0; pc_ex = 32'h0;
  endtask

  task automatic do_reset;
    idle;
    set_instr(5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 6'h0, 3'b000, 2'b00, 32'h0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    idle;
    set_instr(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, {1'b1, 4'd1, 1'b0}, 3'b011, 2'b10, 32'h0);
    tick;
    data_1 = $urandom; data_2 = $urandom; imm = $urandom; pc_ex = $urandom;
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
    ex = 6'($urandom); m = 3'b111; wb = 2'b11; flush_ex = 1'b1;
    rst = 1'b1;
    sb.push_back('0);
    tick;
    got = {res, write_register_ex, write_data_ex, m_MEM, wb_MEM};
    want = sb.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL reset got=%h want=%h", got, want); end
    rst = 1'b0;
  endtask

  task automatic test_rtype_add;
    do_reset;
    set_instr(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, {1'b1, 4'd15, 1'b0}, 3'b000, 2'b10, 32'h20);
    #1;
    n_cmp++;
    if (zero !== 1'b0) begin n_err++; $display("FAIL add_zero got=%b want=0", zero); end
    n_cmp++;
    if (over !== 1'b0) begin n_err++; $display("FAIL add_over got=%b want=0", over); end
    sb.push_back({32'd12, 5'd3, 32'd7, 3'b000, 2'b10});
    tick;
    got = {res, write_register_ex, write_data_ex, m_MEM, wb_MEM};
    want = sb.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL rtype_add got=%h want=%h", got, want); end

    set_instr(5'd5, 5'd6, 5'd3, 32'd9, 32'd9, {1'b1, 4'd15, 1'b0}, 3'b000, 2'b10, 32'h22);
    #1;
    n_cmp++;
    if (zero !== 1'b1) begin n_err++; $display("FAIL sub_zero got=%b want=1", zero); end
    sb.push_back({32'd0, 5'd3, 32'd9, 3'b000, 2'b10});
    tick;
    got = {res, write_register_ex, write_data_ex, m_MEM, wb_MEM};
    want = sb.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL rtype_sub got=%h want=%h", got, want); end
  endtask

  task automatic test_alu_ops;
    do_reset;
    for (int i = 0; i < 30; i++) begin
      set_instr(5'd2, 5'd3, 5'd1, VEC[i].a, VEC[i].b, {1'b1, VEC[i].op, 1'b0},
                3'b000, 2'b00, VEC[i].im);
      #1;
      n_cmp++;
      if (zero !== (VEC[i].r == 32'h0)) begin
        n_err++; $display("FAIL alu_zero[%0d] got=%b want=%b", i, zero, (VEC[i].r == 32'h0));
      end
      n_cmp++;
      if (over !== 1'b0) begin n_err++; $display("FAIL alu_over[%0d] got=%b want=0", i, over); end
      sb.push_back({VEC[i].r, 5'd1, VEC[i].b, 3'b000, 2'b00});
      tick;
      got = {res, write_register_ex, write_data_ex, m_MEM, wb_MEM};
      want = sb.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL alu_op[%0d] got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_overflow;
    do_reset;
    set_instr(5'd1, 5'd2, 5'd8, 32'h7FFFFFFF, 32'd1, {1'b1, 4'd0, 1'b0}, 3'b001, 2'b10, 32'h0);
    #1;
    n_cmp++;
    if (over !== TRAP) begin n_err++; $display("FAIL ovf_add_flag got=%b want=%b", over, TRAP); end
    sb.push_back({32'h80000000, 5'd8, 32'd1, TRAP ? 3'b000 : 3'b001, TRAP ? 2'b00 : 2'b10});
    tick;
    got = {res, write_register_ex, write_data_ex, m_MEM, wb_MEM};
    want = sb.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL ovf_add got=%h want=%h", got, want); end

    set_instr(5'd1, 5'd2, 5'd8, 32'h7FFFFFFF, 32'd1, {1'b1, 4'd1, 1'b0}, 3'b001, 2'b10, 32'h0);
    #1;
    n_cmp++;
    if (over !== 1'b0) begin n_err++; $display("FAIL ovf_addu_flag got=%b want=0", over); end
    sb.push_back({32'h80000000, 5'd8, 32'd1, 3'b001, 2'b10});
    tick;
    got = {res, write_register_ex, write_data_ex, m_MEM, wb_MEM};
    want = sb.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL ovf_addu got=%h want=%h", got, want); end

    set_instr(5'd1, 5'd2, 5'd9, 32'h80000000, 32'd1, {1'b1, 4'd15, 1'b0}, 3'b000, 2'b10, 32'h22);
    #1;
    n_cmp++;
    if (over !== TRAP) begin n_err++; $display("FAIL ovf_sub_flag got=%b want=%b", over, TRAP); end
    sb.push_back({32'h7FFFFFFF, 5'd9, 32'd1, 3'b000, TRAP ? 2'b00 : 2'b10});
    tick;
    got = {res, write_register_ex, write_data_ex, m_MEM, wb_MEM};
    want = sb.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL ovf_sub got=%h want=%h", got, want); end
  endtask

  typedef struct packed {
    logic [4:0]  s, t, d;
    logic [31:0] a, b;
    logic [1:0]  w;
    logic        wrw;
    logic [4:0]  wmem;
    logic [31:0] wdr, r, wd;
  } fwd_step_t;

  localparam fwd_step_t FWD [9] = '{
    '{5'd1,  5'd2,  5'd4, 32'h10, 32'h0, 2'b10, 1'b0, 5'd0, 32'h0,  32'h10, 32'h0},
    '{5'd4,  5'd9,  5'd5, 32'h0,  32'h1, 2'b00, 1'b0, 5'd0, 32'h0,  32'h11, 32'h1},
    '{5'd4,  5'd9,  5'd5, 32'h0,  32'h0, 2'b00, 1'b1, 5'd4, 32'h20, 32'h20, 32'h0},
    '{5'd12, 5'd13, 5'd4, 32'h30, 32'h0, 2'b10, 1'b0, 5'd0, 32'h0,  32'h30, 32'h0},
    '{5'd4,  5'd4,  5'd5, 32'h0,  32'h0, 2'b00, 1'b1, 5'd4, 32'h20, 32'h60, 32'h30},
    '{5'd12, 5'd13, 5'd4, 32'h50, 32'h0, 2'b11, 1'b0, 5'd0, 32'h0,  32'h50, 32'h0},
    '{5'd4,  5'd9,  5'd5, 32'h1,  32'h0, 2'b00, 1'b0, 5'd0, 32'h0,  32'h1,  32'h0},
    '{5'd12, 5'd13, 5'd0, 32'h70, 32'h0, 2'b10, 1'b0, 5'd0, 32'h0,  32'h70, 32'h0},
    '{5'd0,  5'd0,  5'd5, 32'h0,  32'h2, 2'b00, 1'b1, 5'd0, 32'h99, 32'h2,  32'h2}
  };

  task automatic test_forwarding;
    do_reset;
    for (int i = 0; i < 9; i++) begin
      set_instr(FWD[i].s, FWD[i].t, FWD[i].d, FWD[i].a, FWD[i].b, {1'b1, 4'd1, 1'b0},
                3'b000, FWD[i].w, 32'h0);
      wb_reg_write = FWD[i].wrw; write_register_mem = FWD[i].wmem; write_data_reg = FWD[i].wdr;
      sb.push_back({FWD[i].r, FWD[i].d, FWD[i].wd, 3'b000, FWD[i].w});
      tick;
      got = {res, write_register_ex, write_data_ex, m_MEM, wb_MEM};
      want = sb.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL forward[%0d] got=%h want=%h", i, got, want); end
    end
    idle;
  endtask

  task automatic test_imm_store;
    do_reset;
    set_instr(5'd1, 5'd2, 5'd6, 32'h1234, 32'h0, {1'b1, 4'd1, 1'b0}, 3'b000, 2'b10, 32'h0);
    sb.push_back({32'h1234, 5'd6, 32'h0, 3'b000, 2'b10});
    tick;
    got = {res, write_register_ex, write_data_ex, m_MEM, wb_MEM};
    want = sb.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL store_src got=%h want=%h", got, want); end

    set_instr(5'd7, 5'd6, 5'd9, 32'h100, 32'hDEAD, {1'b0, 4'd0, 1'b1}, 3'b001, 2'b00, 32'hFFFFFFFC);
    #1;
    n_cmp++;
    if (over !== 1'b0) begin n_err++; $display("FAIL store_over got=%b want=0", over); end
    sb.push_back({32'hFC, 5'd6, 32'h1234, 3'b001, 2'b00});
    tick;
    got = {res, write_register_ex, write_data_ex, m_MEM, wb_MEM};
    want = sb.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL store got=%h want=%h", got, want); end
  endtask

  task automatic test_flush;
    do_reset;
    set_instr(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, {1'b1, 4'd15, 1'b0}, 3'b010, 2'b10, 32'h20);
    flush_ex = 1'b1;
    sb.push_back({32'd12, 5'd3, 32'd7, 3'b000, 2'b00});
    tick;
    got = {res, write_register_ex, write_data_ex, m_MEM, wb_MEM};
    want = sb.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL flush got=%h want=%h", got, want); end
    flush_ex = 1'b0;
    set_instr(5'd3, 5'd3, 5'd4, 32'd1, 32'd1, {1'b1, 4'd1, 1'b0}, 3'b000, 2'b00, 32'h0);
    sb.push_back({32'd2, 5'd4, 32'd1, 3'b000, 2'b00});
    tick;
    got = {res, write_register_ex, write_data_ex, m_MEM, wb_MEM};
    want = sb.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL flush_nofwd got=%h want=%h", got, want); end
  endtask

  task automatic test_link;
    do_reset;
    pc_ex = 32'h40;
    set_instr(5'd1, 5'd5, 5'd7, 32'h0, 32'hAA, {1'b1, 4'd14, 1'b0}, 3'b000, 2'b10, 32'h0);
    sb.push_back({32'h48, 5'd31, 32'hAA, 3'b000, 2'b10});
    tick;
    got = {res, write_register_ex, write_data_ex, m_MEM, wb_MEM};
    want = sb.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL link got=%h want=%h", got, want); end
    idle;
  endtask

  task automatic test_back_to_back;
    logic [31:0] p_res, fa, fb, r;
    logic [4:0]  p_wr;
    logic [1:0]  p_wb, w;
    logic [3:0]  op;
    do_reset;
    p_res = 32'h0; p_wr = 5'd0; p_wb = 2'b00;
    for (int i = 0; i < 40; i++) begin
      rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
      data_1 = $urandom; data_2 = $urandom;
      case ($urandom_range(0, 2))
        0:       op = 4'd1;
        1:       op = 4'd3;
        default: op = 4'd6;
      endcase
      case ($urandom_range(0, 2))
        0:       w = 2'b00;
        1:       w = 2'b10;
        default: w = 2'b11;
      endcase
      ex = {1'b1, op, 1'b0}; m = 3'b000; wb = w; imm = 32'h0;
      wb_reg_write = 1'($urandom_range(0, 1));
      write_register_mem = 5'($urandom_range(0, 3));
      write_data_reg = $urandom;
      fa = data_1;
      if (p_wb == 2'b10 && p_wr != 5'd0 && p_wr == rs) fa = p_res;
      else if (wb_reg_write && write_register_mem != 5'd0 && write_register_mem == rs) fa = write_data_reg;
      fb = data_2;
      if (p_wb == 2'b10 && p_wr != 5'd0 && p_wr == rt) fb = p_res;
      else if (wb_reg_write && write_register_mem != 5'd0 && write_register_mem == rt) fb = write_data_reg;
      r = (op == 4'd1) ? fa + fb : (op == 4'd3) ? fa - fb : fa ^ fb;
      sb.push_back({r, rd, fb, 3'b000, w});
      tick;
      got = {res, write_register_ex, write_data_ex, m_MEM, wb_MEM};
      want = sb.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL b2b[%0d] got=%h want=%h", i, got, want); end
      p_res = r; p_wr = rd; p_wb = w;
    end
    idle;
  endtask

  initial begin
    rst = 1'b0;
    idle;
    set_instr(5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 6'h0, 3'b000, 2'b00, 32'h0);
    #2;
    test_reset;
    test_rtype_add;
    test_alu_ops;
    test_overflow;
    test_forwarding;
    test_imm_store;
    test_flush;
    test_link;
    test_back_to_back;
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_left got=%0d want=0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
